// File: rtl/axi4_lite_read_slave_if.sv
// AXI4-Lite read-channel bundle (AR + R) between a read master and axi4_lite_read_slave.
// Same-cycle valid/ready handshakes on both channels; no storage in the interface itself.
interface axi4_lite_read_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport master (
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi4_lite_read_slave.sv
// AXI4-Lite single-beat read slave over a 1-cycle synchronous memory; define AXI_RSLV_ALIGN_CHECK_EN for SLVERR on misaligned hits.
// AR->R latency 2 cycles on a hit, 1 on an error; one read outstanding, ARREADY low until the R handshake, R held stable while RREADY=0.
module axi4_lite_read_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  localparam int                   MEM_AW     = $clog2(MEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  axi4_lite_read_slave_if.slave  s_axi,
  output logic                   mem_rd_en,
  output logic [MEM_AW-1:0]      mem_addr,
  input  logic [DATA_WIDTH-1:0]  mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_RESP     = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_WORDS = ADDR_WIDTH'(MEM_DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  fill_q, fill_d;

  logic [ADDR_WIDTH-1:0] ar_word;
  logic [ADDR_WIDTH-1:0] rd_word;
  logic                  ar_hit;
  logic                  ar_hs;
  logic                  r_hs;
`ifdef AXI_RSLV_ALIGN_CHECK_EN
  logic                  ar_misaligned;
`endif

  // Offset wraps modulo 2^ADDR_WIDTH, so addresses below the base land far out of range.
  function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
    return (a - BASE_ADDR) >> 2;
  endfunction

  assign ar_word = word_index(s_axi.S_AXI_ARADDR);
  assign rd_word = word_index(addr_q);
  assign ar_hit  = ar_word < DEPTH_WORDS;
`ifdef AXI_RSLV_ALIGN_CHECK_EN
  assign ar_misaligned = |s_axi.S_AXI_ARADDR[1:0];
`endif

  assign s_axi.S_AXI_ARREADY = !rst && (state_q == ST_IDLE);
  assign ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
  assign r_hs  = s_axi.S_AXI_RVALID && s_axi.S_AXI_RREADY;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    fill_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          addr_d = s_axi.S_AXI_ARADDR;
          if (!ar_hit) begin
            rdata_d = '0;
            rresp_d = RESP_DECERR;
            state_d = ST_RESP;
          end
`ifdef AXI_RSLV_ALIGN_CHECK_EN
          else if (ar_misaligned) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
            state_d = ST_RESP;
          end
`endif
          else begin
            state_d = ST_MEM_READ;
          end
        end
      end
      ST_MEM_READ: begin
        rresp_d = RESP_OKAY;
        fill_d  = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // Memory data is only guaranteed in the first response cycle; latch it there.
        if (fill_q) begin
          rdata_d = mem_rdata;
        end
        if (r_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      fill_q  <= fill_d;
    end
  end

  assign mem_rd_en = (state_q == ST_MEM_READ);
  assign mem_addr  = mem_rd_en ? MEM_AW'(rd_word) : '0;

  assign s_axi.S_AXI_RVALID = (state_q == ST_RESP);
  assign s_axi.S_AXI_RDATA  = !s_axi.S_AXI_RVALID ? '0 :
                              fill_q              ? mem_rdata : rdata_q;
  assign s_axi.S_AXI_RRESP  = s_axi.S_AXI_RVALID ? rresp_q : RESP_OKAY;

endmodule

// File: tb/tb_axi4_lite_read_slave.sv
// Bench for axi4_lite_read_slave: two instances (base 0 and base 0x100) sharing one memory image.
// Honours AXI_RSLV_ALIGN_CHECK_EN for the expected responses of misaligned hits.
module tb_axi4_lite_read_slave;

  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;
  localparam logic [1:0] DE = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi4_lite_read_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
  axi4_lite_read_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();

  logic [31:0] araddr;
  logic        arvalid, rready, sel1;

  assign if0.S_AXI_ARADDR  = araddr;
  assign if0.S_AXI_ARVALID = arvalid & ~sel1;
  assign if0.S_AXI_RREADY  = rready & ~sel1;
  assign if1.S_AXI_ARADDR  = araddr;
  assign if1.S_AXI_ARVALID = arvalid & sel1;
  assign if1.S_AXI_RREADY  = rready & sel1;

  logic [31:0] mem [1024];
  logic        mem_rd_en0, mem_rd_en1;
  logic [9:0]  mem_addr0, mem_addr1;
  logic [31:0] mem_rdata0, mem_rdata1;

  // Read data is only meaningful the cycle after the strobe; garbage otherwise.
  always @(posedge clk) mem_rdata0 <= mem_rd_en0 ? mem[mem_addr0] : $urandom;
  always @(posedge clk) mem_rdata1 <= mem_rd_en1 ? mem[mem_addr1] : $urandom;

  axi4_lite_read_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .rst(rst), .s_axi(if0.slave),
    .mem_rd_en(mem_rd_en0), .mem_addr(mem_addr0), .mem_rdata(mem_rdata0));

  axi4_lite_read_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .BASE_ADDR(32'h100)) u_dut1 (
    .clk(clk), .rst(rst), .s_axi(if1.slave),
    .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1));

  logic        arready_s, rvalid_s, mem_rd_en_s;
  logic [31:0] rdata_s;
  logic [1:0]  rresp_s;
  logic [9:0]  mem_addr_s;
  assign arready_s   = sel1 ? if1.S_AXI_ARREADY : if0.S_AXI_ARREADY;
  assign rvalid_s    = sel1 ? if1.S_AXI_RVALID  : if0.S_AXI_RVALID;
  assign rdata_s     = sel1 ? if1.S_AXI_RDATA   : if0.S_AXI_RDATA;
  assign rresp_s     = sel1 ? if1.S_AXI_RRESP   : if0.S_AXI_RRESP;
  assign mem_rd_en_s = sel1 ? mem_rd_en1 : mem_rd_en0;
  assign mem_addr_s  = sel1 ? mem_addr1  : mem_addr0;

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endfunction

  // One read on the selected instance; entered and left on a negedge.
  task automatic do_read(input string nm, input logic [31:0] a, input int bp,
                         input logic [1:0] e_resp, input logic [31:0] e_data,
                         input int e_lat, input int e_memcnt, input logic [9:0] e_maddr);
    int n, lat, memcnt;
    logic [9:0]  maddr;
    logic [31:0] d0;
    logic [1:0]  r0;
    araddr  = a;
    arvalid = 1'b1;
    rready  = (bp == 0);
    n = 0;
    while (!arready_s && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!arready_s) begin
      chk({nm, " ar_timeout"}, 32'd1, 32'd0);
      arvalid = 1'b0;
      rready  = 1'b0;
      return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    araddr  = $urandom;
    lat = 1; memcnt = 0; maddr = '0;
    while (!rvalid_s && lat < 20) begin
      if (mem_rd_en_s) begin
        memcnt++;
        maddr = mem_addr_s;
      end
      chk({nm, " rdata_idle"}, rdata_s, 32'd0);
      chk({nm, " rresp_idle"}, 32'(rresp_s), 32'd0);
      chk({nm, " arready_busy"}, 32'(arready_s), 32'd0);
      @(negedge clk);
      lat++;
    end
    if (!rvalid_s) begin
      chk({nm, " r_timeout"}, 32'd1, 32'd0);
      rready = 1'b0;
      return;
    end
    chk({nm, " latency"}, 32'(lat), 32'(e_lat));
    chk({nm, " mem_rd_cnt"}, 32'(memcnt), 32'(e_memcnt));
    if (e_memcnt != 0) chk({nm, " mem_addr"}, 32'(maddr), 32'(e_maddr));
    chk({nm, " rresp"}, 32'(rresp_s), 32'(e_resp));
    chk({nm, " rdata"}, rdata_s, e_data);
    chk({nm, " rd_en_in_resp"}, 32'(mem_rd_en_s), 32'd0);
    d0 = rdata_s;
    r0 = rresp_s;
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      chk({nm, " bp_rvalid"}, 32'(rvalid_s), 32'd1);
      chk({nm, " bp_rdata"}, rdata_s, d0);
      chk({nm, " bp_rresp"}, 32'(rresp_s), 32'(r0));
      chk({nm, " bp_arready"}, 32'(arready_s), 32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk({nm, " post_rvalid"}, 32'(rvalid_s), 32'd0);
    chk({nm, " post_rdata"}, rdata_s, 32'd0);
    chk({nm, " post_arready"}, 32'(arready_s), 32'd1);
  endtask

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    int          bp;
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
    int          memcnt;
    logic [9:0]  maddr;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, base, off, w, e_data;
    logic [1:0]  e_resp;

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0]    = 32'h1234_5678;
    mem[4]    = 32'h4444_4444;
    mem[5]    = 32'hDEAD_BEEF;
    mem[6]    = 32'h0BAD_F00D;
    mem[1023] = 32'hCAFE_F00D;

    vecs[0]  = '{1'b0, 32'h0000_0014, 0, OK, 32'hDEAD_BEEF, 2, 1, 10'd5};
    vecs[1]  = '{1'b0, 32'h0000_0014, 2, OK, 32'hDEAD_BEEF, 2, 1, 10'd5};
    vecs[2]  = '{1'b0, 32'h0000_0000, 0, OK, 32'h1234_5678, 2, 1, 10'd0};
    vecs[3]  = '{1'b0, 32'h0000_0FFC, 1, OK, 32'hCAFE_F00D, 2, 1, 10'd1023};
    vecs[4]  = '{1'b0, 32'h0000_1000, 0, DE, 32'h0,         1, 0, 10'd0};
    vecs[5]  = '{1'b0, 32'hFFFF_FFFC, 1, DE, 32'h0,         1, 0, 10'd0};
`ifdef AXI_RSLV_ALIGN_CHECK_EN
    vecs[6]  = '{1'b0, 32'h0000_0016, 0, SE, 32'h0,         1, 0, 10'd0};
    vecs[7]  = '{1'b0, 32'h0000_0013, 2, SE, 32'h0,         1, 0, 10'd0};
`else
    vecs[6]  = '{1'b0, 32'h0000_0016, 0, OK, 32'hDEAD_BEEF, 2, 1, 10'd5};
    vecs[7]  = '{1'b0, 32'h0000_0013, 2, OK, 32'h4444_4444, 2, 1, 10'd4};
`endif
    vecs[8]  = '{1'b1, 32'h0000_00FC, 0, DE, 32'h0,         1, 0, 10'd0};
    vecs[9]  = '{1'b1, 32'h0000_0100, 0, OK, 32'h1234_5678, 2, 1, 10'd0};
    vecs[10] = '{1'b1, 32'h0000_10FC, 0, OK, 32'hCAFE_F00D, 2, 1, 10'd1023};
    vecs[11] = '{1'b1, 32'h0000_1100, 1, DE, 32'h0,         1, 0, 10'd0};
    vecs[12] = '{1'b1, 32'h0000_0000, 0, DE, 32'h0,         1, 0, 10'd0};
    vecs[13] = '{1'b0, 32'h0000_0018, 3, OK, 32'h0BAD_F00D, 2, 1, 10'd6};

    sel1 = 1'b0; arvalid = 1'b0; rready = 1'b0; araddr = '0; rst = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_arready", 32'(if0.S_AXI_ARREADY), 32'd0);
    chk("rst_rvalid", 32'(if0.S_AXI_RVALID), 32'd0);
    chk("rst_rdata", if0.S_AXI_RDATA, 32'd0);
    chk("rst_rresp", 32'(if0.S_AXI_RRESP), 32'd0);
    chk("rst_mem_rd_en", 32'(mem_rd_en0), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr0), 32'd0);
    chk("rst_arready1", 32'(if1.S_AXI_ARREADY), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_arready", 32'(if0.S_AXI_ARREADY), 32'd1);

    for (int i = 0; i < 14; i++) begin
      sel1 = vecs[i].sel;
      do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].bp, vecs[i].resp,
              vecs[i].data, vecs[i].lat, vecs[i].memcnt, vecs[i].maddr);
    end
    sel1 = 1'b0;

    // Backpressure with a second AR waiting behind it.
    araddr = 32'h14; arvalid = 1'b1; rready = 1'b0;
    chk("bpq_arready0", 32'(arready_s), 32'd1);
    @(negedge clk);
    araddr = 32'h18;
    chk("bpq_rd_en", 32'(mem_rd_en_s), 32'd1);
    chk("bpq_mem_addr", 32'(mem_addr_s), 32'd5);
    chk("bpq_arready_mr", 32'(arready_s), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bpq_rvalid%0d", k), 32'(rvalid_s), 32'd1);
      chk($sformatf("bpq_rdata%0d", k), rdata_s, 32'hDEAD_BEEF);
      chk($sformatf("bpq_rresp%0d", k), 32'(rresp_s), 32'd0);
      chk($sformatf("bpq_arready%0d", k), 32'(arready_s), 32'd0);
      if (k == 4) rready = 1'b1;
      @(negedge clk);
    end
    rready = 1'b0;
    chk("bpq_rvalid_done", 32'(rvalid_s), 32'd0);
    chk("bpq_arready2", 32'(arready_s), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    chk("bpq2_rd_en", 32'(mem_rd_en_s), 32'd1);
    chk("bpq2_mem_addr", 32'(mem_addr_s), 32'd6);
    @(negedge clk);
    chk("bpq2_rvalid", 32'(rvalid_s), 32'd1);
    chk("bpq2_rdata", rdata_s, 32'h0BAD_F00D);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("bpq2_rvalid_done", 32'(rvalid_s), 32'd0);

    // Reset during the memory read and during a stalled response.
    araddr = 32'h14; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("rmr_rd_en", 32'(mem_rd_en_s), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rmr_rvalid", 32'(rvalid_s), 32'd0);
    chk("rmr_rd_en_after", 32'(mem_rd_en_s), 32'd0);
    chk("rmr_arready_in_rst", 32'(arready_s), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rmr_arready", 32'(arready_s), 32'd1);
    chk("rmr_rvalid2", 32'(rvalid_s), 32'd0);
    araddr = 32'h18; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    chk("rrs_rvalid_before", 32'(rvalid_s), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rrs_rvalid", 32'(rvalid_s), 32'd0);
    chk("rrs_rd_en", 32'(mem_rd_en_s), 32'd0);
    chk("rrs_rdata", rdata_s, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    do_read("post_rst", 32'h14, 0, OK, 32'hDEAD_BEEF, 2, 1, 10'd5);

    // Randomized reads against an address-map model.
    for (int i = 0; i < 300; i++) begin
      sel1 = 1'($urandom_range(0, 1));
      base = sel1 ? 32'h100 : 32'h0;
      case ($urandom_range(0, 3))
        0:       a = base + 32'($urandom_range(0, 1023)) * 4;
        1:       a = base + 32'($urandom_range(0, 1023)) * 4 + 32'($urandom_range(0, 3));
        2:       a = base + 32'h1000 + 32'($urandom_range(0, 64));
        default: a = $urandom;
      endcase
      off = a - base;
      w   = off / 4;
      if (w >= 1024) begin
        e_resp = DE; e_data = 32'h0;
`ifdef AXI_RSLV_ALIGN_CHECK_EN
      end else if (a % 4 != 0) begin
        e_resp = SE; e_data = 32'h0;
`endif
      end else begin
        e_resp = OK; e_data = mem[w[9:0]];
      end
      do_read($sformatf("rnd%0d", i), a, $urandom_range(0, 3), e_resp, e_data,
              (e_resp == OK) ? 2 : 1, (e_resp == OK) ? 1 : 0, w[9:0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_lite_read_slave.md
Name: axi4_lite_read_slave

Overview:
AXI4-Lite read-channel slave that serves single-beat reads from the SoC's word-addressed synchronous memory (1-cycle read latency). It sits directly downstream of the core's AXI4-Lite read master and accepts its AR/R traffic. It decodes the address window, drives the memory read port, and returns data with a response code. One outstanding transaction at a time.

Parameters:
ADDR_WIDTH, 32, AXI address width in bits
DATA_WIDTH, 32, AXI/memory data width in bits (word = DATA_WIDTH/8 bytes, fixed 4 here)
MEM_DEPTH, 1024, memory depth in words; MEM_AW = $clog2(MEM_DEPTH)
BASE_ADDR, 32'h0000_0000, byte address of memory word 0

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
S_AXI_ARADDR  input  ADDR_WIDTH  read address
S_AXI_ARVALID  input  1  read address valid
S_AXI_ARREADY  output  1  slave accepts address
S_AXI_RDATA  output  DATA_WIDTH  read data
S_AXI_RRESP  output  2  00 OKAY, 10 SLVERR, 11 DECERR
S_AXI_RVALID  output  1  read data valid
S_AXI_RREADY  input  1  master accepts data
mem_rd_en  output  1  memory read strobe
mem_addr  output  MEM_AW  memory word index
mem_rdata  input  DATA_WIDTH  memory data, valid the cycle after mem_rd_en

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- States: ST_IDLE, ST_MEM_READ, ST_RESP.
- Reset: state ST_IDLE, addr_q=0, rdata_q=0, rresp_q=00. Outputs: S_AXI_ARREADY=0 while rst=1, else 1 in ST_IDLE. S_AXI_RVALID=0, S_AXI_RDATA=0, S_AXI_RRESP=00, mem_rd_en=0, mem_addr=0.
- ST_IDLE: ARREADY=1. On ARVALID&ARREADY (cycle T), register ARADDR into addr_q and compute decode:
  - offset = ARADDR - BASE_ADDR, ADDR_WIDTH-bit unsigned, wraps. An address below the base therefore wraps to a large offset and decodes out of range.
  - word = offset >> 2.
  - hit = (word < MEM_DEPTH).
  - hit: go to ST_MEM_READ.
  - miss: rdata_q=0, rresp_q=11 (DECERR), go to ST_RESP.
- ST_MEM_READ (T+1): ARREADY=0, mem_rd_en=1, mem_addr=word[MEM_AW-1:0] from addr_q. Next edge: rdata_q=mem_rdata, rresp_q=00, go to ST_RESP.
- ST_RESP: RVALID=1, RDATA=rdata_q, RRESP=rresp_q. All three hold stable until RREADY=1. On RVALID&RREADY, go to ST_IDLE; RVALID=0 the next cycle.
- Latency (ARVALID to RVALID): 2 cycles on a hit, 1 cycle on a miss. Minimum back-to-back spacing: a new AR is accepted the cycle after the R handshake.
- ARREADY=0 in ST_MEM_READ and ST_RESP. ARVALID arriving then is held off; no address is dropped or captured early.
- RDATA=0 and RRESP=00 whenever RVALID=0.
- mem_rd_en is a single-cycle pulse per hit; never asserted on a miss.
- Low address bits [1:0] are ignored unless the optional feature is enabled.
- Simultaneous events: RREADY arriving before RVALID is ignored. ARVALID in the same cycle as the R handshake is not accepted until ST_IDLE.
- Reset mid-operation, in any state: next edge goes to ST_IDLE with RVALID=0; the pending response is discarded and mem_rd_en=0.

Optional Feature:
AXI_RSLV_ALIGN_CHECK_EN:
- Defined: in ST_IDLE, an address with ARADDR[1:0]!=00 that also hits returns SLVERR (10) with RDATA=0. It goes directly to ST_RESP (1-cycle latency) and makes no memory access. A miss still returns DECERR, which takes priority.
- Undefined: ARADDR[1:0] is ignored; a misaligned hit reads the containing word with OKAY.

Test Plan:
- Hit read: mem[5]=32'hDEAD_BEEF, ARADDR=32'h14 with RREADY held 1. Required: ARREADY handshake at T, mem_rd_en=1 with mem_addr=5 at T+1, then RVALID=1 with RDATA=DEAD_BEEF and RRESP=00 at T+2, lasting 1 cycle.
- Backpressure: same read with RREADY=0 for 4 cycles. Required: RVALID, RDATA and RRESP stable for all 4 cycles. ARREADY=0 throughout even with a second ARVALID asserted. Handshake on cycle 5; the second AR is accepted the cycle after.
- Decode miss: MEM_DEPTH=1024, ARADDR=32'h1000 and then BASE_ADDR=32'h100 with ARADDR=32'h0FC. Required: each gives RVALID at T+1 with RRESP=11 and RDATA=0; mem_rd_en never asserted.
- Boundary: ARADDR=32'hFFC (last word) gives OKAY with mem_addr=1023; ARADDR=32'h1000 gives DECERR.
- Reset mid-op: assert rst in ST_MEM_READ and again in ST_RESP with RREADY=0. Required: next cycle RVALID=0 and mem_rd_en=0; after rst deasserts, ARREADY=1 and a new read completes normally.
- Alignment: ARADDR=32'h16. With AXI_RSLV_ALIGN_CHECK_EN: RRESP=10, RDATA=0, no mem_rd_en. Without it: mem_addr=5, RRESP=00.
